// File: rtl/arb_pkg.sv
// Shared types for the arbiter requester: FSM state encoding and burst descriptor.
package arb_pkg;

    localparam int unsigned ARB_AW = 16;
    localparam int unsigned ARB_LW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2
    } arb_req_state_t;

    typedef struct packed {
        logic [ARB_AW-1:0] addr;
        logic [ARB_LW-1:0] len;
    } arb_desc_t;

endpackage

// File: rtl/arb_requester_if.sv
// Descriptor intake, arbiter request/grant and burst bus of one requester port.
interface arb_requester_if #(
    parameter int unsigned AW    = 16,
    parameter int unsigned LW    = 4,
    parameter int unsigned DEPTH = 4
) ();
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic          desc_valid;
    logic          desc_ready;
    logic [AW-1:0] desc_addr;
    logic [LW-1:0] desc_len;
    logic          req;
    logic          gnt;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_addr;
    logic          out_last;
    logic          starve;
    logic [CW-1:0] fifo_count;

    // Requester side
    modport master (
        input  desc_valid, desc_addr, desc_len, gnt, out_ready,
        output desc_ready, req, out_valid, out_addr, out_last, starve, fifo_count
    );

    // Upstream / arbiter / bus side
    modport slave (
        output desc_valid, desc_addr, desc_len, gnt, out_ready,
        input  desc_ready, req, out_valid, out_addr, out_last, starve, fifo_count
    );
endinterface

// File: rtl/arb_desc_fifo.sv
// Synchronous descriptor FIFO; a push when full is dropped even with a same-cycle pop.
module arb_desc_fifo
    import arb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  arb_desc_t                    i_push_desc,
    input  logic                         i_pop,
    output arb_desc_t                    o_head,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    arb_desc_t        r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Storage write; contents need no reset since the count gates reads
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_desc;
        end
    end

    // Pointer and occupancy tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/arb_requester.sv
// Arbiter client front end: queues burst descriptors, requests the bus and plays bursts out.
module arb_requester
    import arb_pkg::*;
#(
    parameter int unsigned AW           = ARB_AW,
    parameter int unsigned LW           = ARB_LW,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 64
) (
    input  logic             clk,
    input  logic             rst,
    arb_requester_if.master  bus
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    arb_req_state_t r_state;
    arb_req_state_t w_state_nxt;
    logic [AW-1:0]  r_burst_addr;
    logic [LW-1:0]  r_beat_cnt;
    logic [SW-1:0]  r_starve_cnt;

    arb_desc_t      w_push_desc;
    arb_desc_t      w_head;
    logic           w_push;
    logic           w_grant;
    logic           w_beat_hs;
    logic           w_last_hs;
    logic           w_fifo_full;
    logic           w_fifo_empty;
    logic [CW-1:0]  w_fifo_count;

    assign w_push           = bus.desc_valid && !w_fifo_full;
    assign w_push_desc.addr = ARB_AW'(bus.desc_addr);
    assign w_push_desc.len  = ARB_LW'(bus.desc_len);
    assign w_grant          = (r_state == REQ) && bus.gnt;
    assign w_beat_hs        = (r_state == XFER) && bus.out_ready;
    assign w_last_hs        = w_beat_hs && (r_beat_cnt == '0);

    arb_desc_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_desc (w_push_desc),
        .i_pop       (w_grant),
        .o_head      (w_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // FSM next state; a push on the last-beat edge keeps us requesting
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (!w_fifo_empty) w_state_nxt = REQ;
            REQ:     if (bus.gnt)       w_state_nxt = XFER;
            XFER:    if (w_last_hs)     w_state_nxt = (!w_fifo_empty || w_push) ? REQ : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Burst address and remaining-beat counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_burst_addr <= '0;
            r_beat_cnt   <= '0;
        end else if (w_grant) begin
            r_burst_addr <= AW'(w_head.addr);
            r_beat_cnt   <= LW'(w_head.len);
        end else if (w_beat_hs) begin
            r_burst_addr <= r_burst_addr + AW'(1);
            r_beat_cnt   <= r_beat_cnt - LW'(1);
        end
    end

    // Starvation watchdog: saturating count of ungranted cycles in REQ
    always_ff @(posedge clk) begin
        if (rst || w_grant) begin
            r_starve_cnt <= '0;
        end else if ((r_state == REQ) && (r_starve_cnt != SW'(STARVE_LIMIT))) begin
            r_starve_cnt <= r_starve_cnt + SW'(1);
        end
    end

    assign bus.req        = (r_state == REQ);
    assign bus.out_valid  = (r_state == XFER);
    assign bus.out_addr   = r_burst_addr;
    assign bus.out_last   = (r_state == XFER) && (r_beat_cnt == '0);
    assign bus.starve     = (r_starve_cnt == SW'(STARVE_LIMIT));
    assign bus.desc_ready = !w_fifo_full;
    assign bus.fifo_count = w_fifo_count;
endmodule

// File: tb/tb_arb_requester.sv
// Directed self-checking bench for arb_requester.
module tb_arb_requester;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    arb_requester_if #(.AW(16), .LW(4), .DEPTH(4)) bus ();

    arb_requester #(.AW(16), .LW(4), .DEPTH(4), .STARVE_LIMIT(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Single-cycle descriptor push
    task automatic push(input logic [15:0] a, input logic [3:0] l);
        bus.desc_valid = 1'b1;
        bus.desc_addr  = a;
        bus.desc_len   = l;
        tick();
        bus.desc_valid = 1'b0;
    endtask

    // Wait (bounded) for req, then pulse gnt for one cycle
    task automatic grant();
        for (int i = 0; i < 10 && bus.req !== 1'b1; i++) tick();
        chk("req_before_gnt", 32'(bus.req), 32'd1);
        bus.gnt = 1'b1;
        tick();
        bus.gnt        = 1'b0;
        bus.desc_valid = 1'b0;
        chk("req_after_gnt", 32'(bus.req), 32'd0);
    endtask

    // Play out one burst, checking every valid cycle against the expected beat
    task automatic collect(input logic [15:0] a0, input int n, input bit stall);
        int k;
        int cyc;
        logic [5:0] pat;
        logic rdy;
        k   = 0;
        cyc = 0;
        pat = 6'b101001;
        while (k < n && cyc < 40) begin
            rdy = stall ? ((cyc < 6) ? pat[cyc] : 1'b1) : 1'b1;
            bus.out_ready = rdy;
            chk("out_valid", 32'(bus.out_valid), 32'd1);
            chk("out_addr", 32'(bus.out_addr), 32'(16'(a0 + 16'(k))));
            chk("out_last", 32'(bus.out_last), 32'(k == n - 1));
            if (rdy) k++;
            cyc++;
            tick();
        end
        bus.out_ready = 1'b0;
        chk("beats", 32'(k), 32'(n));
        if (!stall) chk("xfer_cycles", 32'(cyc), 32'(n));
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst            = 1'b1;
        bus.desc_valid = 1'b0;
        bus.desc_addr  = '0;
        bus.desc_len   = '0;
        bus.gnt        = 1'b0;
        bus.out_ready  = 1'b0;
        tick();
        tick();
        chk("rst_req", 32'(bus.req), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_last", 32'(bus.out_last), 32'd0);
        chk("rst_out_addr", 32'(bus.out_addr), 32'd0);
        chk("rst_starve", 32'(bus.starve), 32'd0);
        chk("rst_fifo_count", 32'(bus.fifo_count), 32'd0);
        chk("rst_desc_ready", 32'(bus.desc_ready), 32'd1);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("idle_req", 32'(bus.req), 32'd0);
        chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
        chk("idle_starve", 32'(bus.starve), 32'd0);
        chk("idle_fifo_count", 32'(bus.fifo_count), 32'd0);
        chk("idle_desc_ready", 32'(bus.desc_ready), 32'd1);

        // Single burst, ready held high
        push(16'h1000, 4'd2);
        chk("push_count", 32'(bus.fifo_count), 32'd1);
        chk("push_req_lat", 32'(bus.req), 32'd0);
        tick();
        chk("req_rise", 32'(bus.req), 32'd1);
        grant();
        collect(16'h1000, 3, 1'b0);
        chk("b1_idle_req", 32'(bus.req), 32'd0);
        chk("b1_idle_valid", 32'(bus.out_valid), 32'd0);

        // Same burst with stalls
        push(16'h1000, 4'd2);
        grant();
        collect(16'h1000, 3, 1'b1);
        chk("b2_idle_valid", 32'(bus.out_valid), 32'd0);

        // Fill the FIFO, then try a 5th push alone and alongside a pop
        push(16'h2000, 4'd0);
        push(16'h3000, 4'd1);
        push(16'h4000, 4'd2);
        push(16'h5000, 4'd3);
        chk("full_count", 32'(bus.fifo_count), 32'd4);
        chk("full_desc_ready", 32'(bus.desc_ready), 32'd0);
        push(16'h6000, 4'd0);
        chk("full_drop_count", 32'(bus.fifo_count), 32'd4);
        bus.desc_valid = 1'b1;
        bus.desc_addr  = 16'h6000;
        bus.desc_len   = 4'd0;
        grant();
        chk("full_pop_count", 32'(bus.fifo_count), 32'd3);
        collect(16'h2000, 1, 1'b0);
        chk("b2b_req0", 32'(bus.req), 32'd1);
        grant();
        collect(16'h3000, 2, 1'b0);
        chk("b2b_req1", 32'(bus.req), 32'd1);
        grant();
        collect(16'h4000, 3, 1'b0);
        chk("b2b_req2", 32'(bus.req), 32'd1);
        grant();
        collect(16'h5000, 4, 1'b0);
        chk("b2b_end_req", 32'(bus.req), 32'd0);
        chk("b2b_end_count", 32'(bus.fifo_count), 32'd0);

        // Starvation watchdog
        push(16'h7000, 4'd0);
        tick();
        chk("st_req", 32'(bus.req), 32'd1);
        for (int i = 0; i < 63; i++) tick();
        chk("starve_63", 32'(bus.starve), 32'd0);
        tick();
        chk("starve_64", 32'(bus.starve), 32'd1);
        tick();
        tick();
        chk("starve_sat", 32'(bus.starve), 32'd1);
        grant();
        chk("starve_clr", 32'(bus.starve), 32'd0);
        collect(16'h7000, 1, 1'b0);

        // Address wrap, then reset mid-burst with a queued descriptor
        push(16'hFFFF, 4'd1);
        grant();
        chk("wrap_b0", 32'(bus.out_addr), 32'h0000FFFF);
        chk("wrap_b0_last", 32'(bus.out_last), 32'd0);
        bus.out_ready  = 1'b1;
        bus.desc_valid = 1'b1;
        bus.desc_addr  = 16'h8000;
        bus.desc_len   = 4'd0;
        tick();
        bus.out_ready  = 1'b0;
        bus.desc_valid = 1'b0;
        chk("wrap_b1", 32'(bus.out_addr), 32'h00000000);
        chk("wrap_b1_last", 32'(bus.out_last), 32'd1);
        chk("wrap_count", 32'(bus.fifo_count), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_count", 32'(bus.fifo_count), 32'd0);
        chk("mid_rst_ready", 32'(bus.desc_ready), 32'd1);
        tick();
        chk("mid_rst_req", 32'(bus.req), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
